// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among functional-unit writeback ports,
// a registered one-cycle result broadcast, and a saturating conflict counter.
module cdb_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    input  logic [NUM_REQ*ROB_ADDR_WIDTH-1:0]  req_rob_tag_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data_i,
    input  logic [NUM_REQ-1:0]                 req_exc_i,
    output logic                               result_valid_o,
    output logic [ROB_ADDR_WIDTH-1:0]          result_rob_tag_o,
    output logic [DATA_WIDTH-1:0]              result_data_o,
    output logic                               result_exc_o,
    output logic [$clog2(NUM_REQ)-1:0]         result_src_o,
    output logic [CNT_WIDTH-1:0]               conflict_cnt_o,
    input  logic                               conflict_cnt_clr_i
);

    localparam int SRC_W = $clog2(NUM_REQ);

    logic [SRC_W-1:0]          rr_ptr_r;
    logic [SRC_W:0]            winner_s;
    logic [SRC_W-1:0]          grant_idx_s;
    logic [NUM_REQ-1:0]        grant_s;
    logic                      grant_any_s;
    logic [ROB_ADDR_WIDTH-1:0] sel_tag_s;
    logic [DATA_WIDTH-1:0]     sel_data_s;
    logic                      sel_exc_s;
    logic                      multi_valid_s;
    logic [SRC_W-1:0]          ptr_next_s;

    // Returns {found, index} of the first valid requester at or after ptr, wrapping.
    function automatic logic [SRC_W:0] pick_winner(input logic [NUM_REQ-1:0] valid,
                                                   input logic [SRC_W-1:0]   ptr);
        logic [SRC_W:0]   res;
        logic [SRC_W-1:0] idx_l;
        int               pos;
        res = {(SRC_W+1){1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end else begin
                pos = pos;
            end
            idx_l = pos[SRC_W-1:0];
            if (!res[SRC_W] && valid[idx_l]) begin
                res = {1'b1, idx_l};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Combinational grant; suppressed during flush and while reset is held.
    always_comb begin
        winner_s    = pick_winner(req_valid_i, rr_ptr_r);
        grant_idx_s = winner_s[SRC_W-1:0];
        grant_s     = {NUM_REQ{1'b0}};
        if (winner_s[SRC_W] && !flush_i && !rst_i) begin
            grant_any_s          = 1'b1;
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_any_s = 1'b0;
        end
    end

    assign req_ready_o = grant_s;

    // Payload mux for the selected requester and the next round-robin pointer.
    always_comb begin
        sel_tag_s  = {ROB_ADDR_WIDTH{1'b0}};
        sel_data_s = {DATA_WIDTH{1'b0}};
        sel_exc_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == SRC_W'(i)) begin
                sel_tag_s  = req_rob_tag_i[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
                sel_data_s = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_exc_s  = req_exc_i[i];
            end else begin
                sel_exc_s  = sel_exc_s;
            end
        end
        if (grant_idx_s == SRC_W'(NUM_REQ-1)) begin
            ptr_next_s = {SRC_W{1'b0}};
        end else begin
            ptr_next_s = grant_idx_s + SRC_W'(1'b1);
        end
    end

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign multi_valid_s = |(req_valid_i & (req_valid_i - {{(NUM_REQ-1){1'b0}}, 1'b1}));

    // Result bus register: one-cycle broadcast, payload holds when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_valid_o   <= 1'b0;
            result_rob_tag_o <= {ROB_ADDR_WIDTH{1'b0}};
            result_data_o    <= {DATA_WIDTH{1'b0}};
            result_exc_o     <= 1'b0;
            result_src_o     <= {SRC_W{1'b0}};
        end else if (grant_any_s) begin
            result_valid_o   <= 1'b1;
            result_rob_tag_o <= sel_tag_s;
            result_data_o    <= sel_data_s;
            result_exc_o     <= sel_exc_s;
            result_src_o     <= grant_idx_s;
        end else begin
            result_valid_o   <= 1'b0;
        end
    end

    // Round-robin pointer: restart at 0 on flush, advance past each winner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r <= {SRC_W{1'b0}};
        end else if (flush_i) begin
            rr_ptr_r <= {SRC_W{1'b0}};
        end else if (grant_any_s) begin
            rr_ptr_r <= ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Saturating conflict counter; clear wins over increment, flush cycles are not counted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= {CNT_WIDTH{1'b0}};
        end else if (conflict_cnt_clr_i) begin
            conflict_cnt_o <= {CNT_WIDTH{1'b0}};
        end else if (!flush_i && multi_valid_s && (conflict_cnt_o != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt_o <= conflict_cnt_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            conflict_cnt_o <= conflict_cnt_o;
        end
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single Common Data Bus between NUM_REQ functional-unit writeback ports.
- Each cycle it grants at most one requester, using round-robin order, and registers the winner onto the result bus.
- The result bus feeds the reservation station's result-forwarding inputs (result_valid/result_rob_tag/result_data) and the ROB.
- It also counts arbitration conflicts for performance monitoring.

Parameters:
- NUM_REQ, 4, number of functional-unit requesters; must be >= 2.
- DATA_WIDTH, XLEN (32), result data width.
- ROB_ADDR_WIDTH, ROB_ADDR_WIDTH_G (5), ROB tag width.
- CNT_WIDTH, 16, width of the conflict counter.

Ports:
- clk_i  in  1  system clock; the block has one clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  pipeline flush (synchronous).
- req_valid_i  in  NUM_REQ  per-FU result valid.
- req_ready_o  out  NUM_REQ  per-FU grant; a result transfers when valid && ready.
- req_rob_tag_i  in  NUM_REQ*ROB_ADDR_WIDTH  per-FU ROB tag, packed; requester i occupies slice [i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH].
- req_data_i  in  NUM_REQ*DATA_WIDTH  per-FU result data, packed the same way.
- req_exc_i  in  NUM_REQ  per-FU exception flag.
- result_valid_o  out  1  CDB broadcast valid.
- result_rob_tag_o  out  ROB_ADDR_WIDTH  CDB ROB tag.
- result_data_o  out  DATA_WIDTH  CDB data.
- result_exc_o  out  1  CDB exception flag.
- result_src_o  out  $clog2(NUM_REQ)  index of the granted requester.
- conflict_cnt_o  out  CNT_WIDTH  saturating count of cycles with >1 requester valid.
- conflict_cnt_clr_i  in  1  synchronous clear of conflict_cnt_o.

Behaviour:
- Reset (rst_i=1, async) sets:
  - result_valid_o=0, result_rob_tag_o=0, result_data_o=0, result_exc_o=0, result_src_o=0;
  - round-robin pointer rr_ptr=0, conflict_cnt_o=0;
  - req_ready_o=0 while rst_i=1.
- Grant (combinational):
  - Search requesters rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - The first requester with valid=1 wins and its req_ready_o bit is 1.
  - At most one req_ready_o bit is 1 per cycle. All bits are 0 if no requester is valid or flush_i=1.
  - req_ready_o is independent of result bus state; the CDB has no backpressure.
- Transfer: when grant[i]=1, at the next rising edge:
  - result_valid_o<=1;
  - result_rob_tag_o/result_data_o/result_exc_o <= requester i's fields;
  - result_src_o<=i.
  - Latency is exactly 1 cycle from acceptance to broadcast.
- Broadcast lasts exactly one cycle. With no grant, result_valid_o<=0 next cycle; data/tag/src hold their last values (don't-care when invalid).
- Pointer update:
  - On grant to i, rr_ptr<=(i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - Wrap: a grant to NUM_REQ-1 sets rr_ptr=0.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Requester obligation: a non-granted requester holds valid, tag, data and exc stable until granted. The arbiter never drops a request.
- Flush (flush_i=1):
  - No grant in that cycle.
  - result_valid_o<=0 at the next edge.
  - rr_ptr<=0.
  - conflict_cnt_o is unaffected.
  - A result registered in the cycle before flush_i is still broadcast in the flush cycle; the ROB and RS discard it.
- Conflict counter:
  - Increments by 1 on each non-flush cycle where popcount(req_valid_i)>=2.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - conflict_cnt_clr_i sets it to 0 and takes priority over increment.
- Reset mid-operation: all state returns immediately to reset values; pending requests remain at the FUs and are re-arbitrated from rr_ptr=0 after reset deasserts.
- No combinational path from any req_* input to any result_* output.

Test Plan:
- Reset, then single requester: req_valid_i=4'b0100, tag=7, data=0xDEADBEEF → req_ready_o=4'b0100 in the same cycle. Next cycle: result_valid_o=1, tag=7, data=0xDEADBEEF, src=2. Following cycle: result_valid_o=0.
- All four requesters held valid for 8 cycles from rr_ptr=0 → grant order 0,1,2,3,0,1,2,3. result_src_o follows one cycle later. conflict_cnt_o=8.
- Wrap: rr_ptr=3, req_valid_i=4'b1001 → grant 3, then 0. rr_ptr goes 3→0→1.
- Flush: req_valid_i=4'b0011 with flush_i=1 → req_ready_o=0 and result_valid_o=0 next cycle. The cycle after flush grants requester 0 (rr_ptr reset).
- Counter saturation: CNT_WIDTH=4, 20 cycles of 2 valid requesters → conflict_cnt_o=15. conflict_cnt_clr_i pulse → 0 next cycle.
- Async reset asserted mid-stream between clock edges → result_valid_o=0 and req_ready_o=0 immediately, without waiting for a clock edge.
